// File: rtl/avmm_lvds_bridge_pkg.sv
// Shared constants and types for the AVMM-over-LVDS bridge.
// Covers the packet header layout, the slave front-end FSM states and the timeout fill word.
package avmm_lvds_bridge_pkg;

    localparam int ADDR_W     = 32;
    localparam int BURSTCNT_W = 8;
    localparam int MAX_BURST  = 16;

    localparam int HDR_WR_BIT    = 31;
    localparam int HDR_BURST_BIT = 30;
    localparam int HDR_BE_LSB    = 24;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD
    } avs_state_e;

endpackage

// File: rtl/avmm_lvds_bridge_avs_if_if.sv
// Bundle of the bridge slave front end's Avalon ports, request/response channels and error flag.
// The slave modport is the bridge side; the master modport is the environment side.
interface avmm_lvds_bridge_avs_if_if #(
    parameter int ADDR_W     = avmm_lvds_bridge_pkg::ADDR_W,
    parameter int BURSTCNT_W = avmm_lvds_bridge_pkg::BURSTCNT_W
);
    logic [ADDR_W-1:0]     s0_address_i;
    logic [3:0]            s0_byteenable_i;
    logic [31:0]           s0_writedata_i;
    logic                  s0_write_i;
    logic                  s0_read_i;
    logic [31:0]           s0_readdata_o;
    logic                  s0_waitrequest_o;

    logic [ADDR_W-1:0]     s1_address_i;
    logic [BURSTCNT_W-1:0] s1_burstcount_i;
    logic [31:0]           s1_writedata_i;
    logic                  s1_write_i;
    logic                  s1_read_i;
    logic [31:0]           s1_readdata_o;
    logic                  s1_readdatavalid_o;
    logic                  s1_waitrequest_o;

    logic [31:0]           req_data_o;
    logic                  req_valid_o;

    logic                  resp_rdreq_o;
    logic [31:0]           resp_q_i;
    logic                  resp_rdempty_i;
    logic [BURSTCNT_W-1:0] resp_rdusedw_i;

    logic                  err_o;

    modport slave (
        input  s0_address_i, s0_byteenable_i, s0_writedata_i, s0_write_i, s0_read_i,
        output s0_readdata_o, s0_waitrequest_o,
        input  s1_address_i, s1_burstcount_i, s1_writedata_i, s1_write_i, s1_read_i,
        output s1_readdata_o, s1_readdatavalid_o, s1_waitrequest_o,
        output req_data_o, req_valid_o,
        output resp_rdreq_o,
        input  resp_q_i, resp_rdempty_i, resp_rdusedw_i,
        output err_o
    );

    modport master (
        output s0_address_i, s0_byteenable_i, s0_writedata_i, s0_write_i, s0_read_i,
        input  s0_readdata_o, s0_waitrequest_o,
        output s1_address_i, s1_burstcount_i, s1_writedata_i, s1_write_i, s1_read_i,
        input  s1_readdata_o, s1_readdatavalid_o, s1_waitrequest_o,
        input  req_data_o, req_valid_o,
        input  resp_rdreq_o,
        output resp_q_i, resp_rdempty_i, resp_rdusedw_i,
        input  err_o
    );
endinterface

// File: rtl/avmm_lvds_bridge_avs_if.sv
// Avalon-MM slave front end: serializes s0/s1 transactions into request words and
// turns response words back into read data or write completion.
module avmm_lvds_bridge_avs_if #(
    parameter int          ADDR_W       = avmm_lvds_bridge_pkg::ADDR_W,
    parameter int          BURSTCNT_W   = avmm_lvds_bridge_pkg::BURSTCNT_W,
    parameter int unsigned RESP_TIMEOUT = 4096
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    avmm_lvds_bridge_avs_if_if.slave  bus
);
    import avmm_lvds_bridge_pkg::*;

    localparam int TMO_W = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT + 1);

    avs_state_e            state_q, state_d;
    logic                  sel_s1_q, sel_s1_d;
    logic                  wr_q, wr_d;
    logic [3:0]            be_q, be_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [BURSTCNT_W-1:0] len_q, len_d;
    logic [BURSTCNT_W-1:0] cnt_q, cnt_d;
    logic [BURSTCNT_W-1:0] pop_q, pop_d;
    logic                  rvalid_q, rvalid_d;
    logic                  to_q, to_d;
    logic                  err_q, err_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;

    logic                  in_resp, tmo_fire, beat_avail, rdreq, sel_write;
    logic [BURSTCNT_W-1:0] s1_len;
    logic [31:0]           hdr_word, rd_word;

    logic        s0_wait, s1_wait, s1_rdv, req_valid;
    logic [31:0] s0_rdata, s1_rdata, req_data;

    assign s1_len    = (bus.s1_burstcount_i == '0) ? BURSTCNT_W'(1) : bus.s1_burstcount_i;
    assign in_resp   = (state_q == ST_WR_ACK) || (state_q == ST_RD);
    assign sel_write = sel_s1_q ? bus.s1_write_i : bus.s0_write_i;
    // A word popped this cycle always wins over an expiring counter.
    assign tmo_fire  = (RESP_TIMEOUT != 0) && in_resp && !rvalid_q && !to_q &&
                       (tmo_q == TMO_W'(RESP_TIMEOUT));
    assign beat_avail = in_resp && (rvalid_q || to_q || tmo_fire);
    assign rdreq     = in_resp && !bus.resp_rdempty_i && (pop_q != '0) && !to_q && !tmo_fire;
    assign rd_word   = rvalid_q ? bus.resp_q_i : TIMEOUT_DATA;

    always_comb begin
        hdr_word                     = '0;
        hdr_word[HDR_WR_BIT]         = wr_q;
        hdr_word[HDR_BURST_BIT]      = sel_s1_q;
        hdr_word[HDR_BE_LSB +: 4]    = be_q;
        hdr_word[BURSTCNT_W-1:0]     = len_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            sel_s1_q <= 1'b0;
            wr_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            pop_q    <= '0;
            rvalid_q <= 1'b0;
            to_q     <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_s1_q <= sel_s1_d;
            wr_q     <= wr_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            pop_q    <= pop_d;
            rvalid_q <= rvalid_d;
            to_q     <= to_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_s1_d = sel_s1_q;
        wr_d     = wr_q;
        be_d     = be_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        pop_d    = pop_q;
        rvalid_d = rdreq;
        to_d     = to_q;
        err_d    = err_q;
        tmo_d    = '0;
        case (state_q)
            ST_IDLE: begin
                to_d = 1'b0;
                if (bus.s0_write_i || bus.s0_read_i) begin
                    sel_s1_d = 1'b0;
                    wr_d     = bus.s0_write_i;
                    be_d     = bus.s0_byteenable_i;
                    addr_d   = bus.s0_address_i;
                    len_d    = BURSTCNT_W'(1);
                    state_d  = ST_HDR;
                end else if (bus.s1_write_i || bus.s1_read_i) begin
                    sel_s1_d = 1'b1;
                    wr_d     = bus.s1_write_i;
                    be_d     = 4'hF;
                    addr_d   = bus.s1_address_i;
                    len_d    = s1_len;
                    state_d  = ST_HDR;
                end
                cnt_d = len_d;
                pop_d = wr_d ? BURSTCNT_W'(1) : len_d;
            end
            ST_HDR:  state_d = ST_ADDR;
            ST_ADDR: state_d = wr_q ? ST_WR_DATA : ST_RD;
            ST_WR_DATA: begin
                if (sel_write) begin
                    cnt_d = cnt_q - BURSTCNT_W'(1);
                    if (cnt_q == BURSTCNT_W'(1)) state_d = ST_WR_ACK;
                end
            end
            ST_WR_ACK, ST_RD: begin
                if (rvalid_q)                           tmo_d = '0;
                else if (tmo_q == TMO_W'(RESP_TIMEOUT)) tmo_d = tmo_q;
                else                                    tmo_d = tmo_q + TMO_W'(1);
                if (rdreq) pop_d = pop_q - BURSTCNT_W'(1);
                if (tmo_fire) begin
                    to_d  = 1'b1;
                    err_d = 1'b1;
                end
                if (beat_avail) begin
                    cnt_d = cnt_q - BURSTCNT_W'(1);
                    if (state_q == ST_WR_ACK || cnt_q == BURSTCNT_W'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s0_wait   = 1'b1;
        s1_wait   = 1'b1;
        s0_rdata  = '0;
        s1_rdata  = '0;
        s1_rdv    = 1'b0;
        req_valid = 1'b0;
        req_data  = '0;
        case (state_q)
            ST_HDR: begin
                req_valid = 1'b1;
                req_data  = hdr_word;
            end
            ST_ADDR: begin
                req_valid = 1'b1;
                req_data  = 32'(addr_q);
                if (sel_s1_q && !wr_q) s1_wait = 1'b0;
            end
            ST_WR_DATA: begin
                if (sel_write) begin
                    req_valid = 1'b1;
                    req_data  = sel_s1_q ? bus.s1_writedata_i : bus.s0_writedata_i;
                    // The last beat stays stalled until the far end acknowledges it.
                    if (cnt_q != BURSTCNT_W'(1)) begin
                        if (sel_s1_q) s1_wait = 1'b0;
                        else          s0_wait = 1'b0;
                    end
                end
            end
            ST_WR_ACK: begin
                if (beat_avail) begin
                    if (sel_s1_q) s1_wait = 1'b0;
                    else          s0_wait = 1'b0;
                end
            end
            ST_RD: begin
                if (beat_avail) begin
                    if (sel_s1_q) begin
                        s1_rdv   = 1'b1;
                        s1_rdata = rd_word;
                    end else begin
                        s0_wait  = 1'b0;
                        s0_rdata = rd_word;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.s0_waitrequest_o   = s0_wait;
    assign bus.s0_readdata_o      = s0_rdata;
    assign bus.s1_waitrequest_o   = s1_wait;
    assign bus.s1_readdata_o      = s1_rdata;
    assign bus.s1_readdatavalid_o = s1_rdv;
    assign bus.req_valid_o        = req_valid;
    assign bus.req_data_o         = req_data;
    assign bus.resp_rdreq_o       = rdreq;
    assign bus.err_o              = err_q;

endmodule

// File: tb/tb_avmm_lvds_bridge_avs_if.sv
// Scoreboard bench for the bridge slave front end: transactions are planned into expected
// request words / read data, a response FIFO stub feeds the bridge, and a monitor compares.
module tb_avmm_lvds_bridge_avs_if;
    import avmm_lvds_bridge_pkg::*;

    localparam int unsigned TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    avmm_lvds_bridge_avs_if_if #(.ADDR_W(ADDR_W), .BURSTCNT_W(BURSTCNT_W)) bus ();

    avmm_lvds_bridge_avs_if #(
        .ADDR_W(ADDR_W),
        .BURSTCNT_W(BURSTCNT_W),
        .RESP_TIMEOUT(TMO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_pop_cyc = -10;
    logic stall;

    logic [31:0] req_exp[$];
    logic [31:0] s0_exp[$];
    logic [31:0] s1_exp[$];
    logic [31:0] resp_fifo[$];
    logic [31:0] s0_wd[$];
    logic [31:0] s1_wd[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: unexpected word %h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Far-end response channel: show-ahead off, q valid the cycle after rdreq, random stalls.
    always @(posedge clk) begin
        if (rst) begin
            bus.resp_q_i       <= '0;
            bus.resp_rdempty_i <= 1'b1;
            bus.resp_rdusedw_i <= '0;
        end else begin
            if (bus.resp_rdreq_o) begin
                if (resp_fifo.size() == 0) unexpected("resp_pop_empty", 32'h0);
                else begin
                    bus.resp_q_i <= resp_fifo.pop_front();
                    last_pop_cyc = cyc;
                end
            end
            stall = ($urandom_range(0, 3) == 0);
            bus.resp_rdempty_i <= (resp_fifo.size() == 0) || stall;
            bus.resp_rdusedw_i <= BURSTCNT_W'(resp_fifo.size());
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req_valid_o) begin
                if (req_exp.size() == 0) unexpected("req_word", bus.req_data_o);
                else check("req_word", bus.req_data_o, req_exp.pop_front());
            end
            if (bus.s1_readdatavalid_o) begin
                if (s1_exp.size() == 0) unexpected("s1_readdata", bus.s1_readdata_o);
                else check("s1_readdata", bus.s1_readdata_o, s1_exp.pop_front());
            end
            if (bus.s0_read_i && !bus.s0_waitrequest_o) begin
                if (s0_exp.size() == 0) unexpected("s0_readdata", bus.s0_readdata_o);
                else check("s0_readdata", bus.s0_readdata_o, s0_exp.pop_front());
            end
            if (bus.resp_rdreq_o) check("rdreq_while_empty", {31'b0, bus.resp_rdempty_i}, 32'h0);
        end
    end

    // Expected packet and response words for one transaction, in service order.
    task automatic plan(input bit s1, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input int n, input logic [31:0] d0);
        int          eff;
        logic [31:0] hdr;
        logic [31:0] w;
        eff = (s1 && n > 0) ? n : 1;
        hdr = (wr ? 32'h8000_0000 : 32'h0) + (s1 ? 32'h4000_0000 : 32'h0) +
              ({28'h0, (s1 ? 4'hF : be)} << 24) + 32'(eff);
        req_exp.push_back(hdr);
        req_exp.push_back(addr);
        for (int i = 0; i < eff; i++) begin
            w = (i == 0) ? d0 : $urandom;
            if (wr) begin
                req_exp.push_back(w);
                if (s1) s1_wd.push_back(w);
                else    s0_wd.push_back(w);
            end else begin
                resp_fifo.push_back(w);
                if (s1) s1_exp.push_back(w);
                else    s0_exp.push_back(w);
            end
        end
        if (wr) resp_fifo.push_back($urandom);
    endtask

    task automatic s0_xfer(input bit wr, input logic [31:0] addr, input logic [3:0] be);
        int guard;
        @(posedge clk); #1;
        bus.s0_address_i    = addr;
        bus.s0_byteenable_i = be;
        if (wr) begin
            bus.s0_writedata_i = s0_wd.pop_front();
            bus.s0_write_i     = 1'b1;
        end else begin
            bus.s0_read_i = 1'b1;
        end
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (bus.s0_waitrequest_o && guard < 400);
        if (bus.s0_waitrequest_o) unexpected("s0_wait_timeout", 32'(guard));
        else if (wr) check("s0_wr_done_after_ack", 32'(cyc), 32'(last_pop_cyc + 1));
        @(posedge clk); #1;
        bus.s0_write_i = 1'b0;
        bus.s0_read_i  = 1'b0;
    endtask

    task automatic s1_read(input logic [31:0] addr, input int n, input bit chk_lat);
        int guard;
        int start;
        @(posedge clk); #1;
        start = cyc;
        bus.s1_address_i    = addr;
        bus.s1_burstcount_i = BURSTCNT_W'(n);
        bus.s1_read_i       = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (bus.s1_waitrequest_o && guard < 400);
        if (bus.s1_waitrequest_o) unexpected("s1_rd_wait_timeout", 32'(guard));
        else if (chk_lat) check("s1_rd_accept_latency", 32'(cyc - start), 32'd2);
        @(posedge clk); #1;
        bus.s1_read_i = 1'b0;
    endtask

    task automatic s1_write(input logic [31:0] addr, input int n);
        int guard;
        int eff;
        eff = (n > 0) ? n : 1;
        @(posedge clk); #1;
        for (int i = 0; i < eff; i++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.s1_write_i = 1'b0;
                @(posedge clk); #1;
            end
            bus.s1_address_i    = addr;
            bus.s1_burstcount_i = BURSTCNT_W'(n);
            bus.s1_writedata_i  = s1_wd.pop_front();
            bus.s1_write_i      = 1'b1;
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (bus.s1_waitrequest_o && guard < 400);
            if (bus.s1_waitrequest_o) unexpected("s1_wr_wait_timeout", 32'(guard));
            else if (i == eff - 1) check("s1_wr_last_after_ack", 32'(cyc), 32'(last_pop_cyc + 1));
            @(posedge clk); #1;
        end
        bus.s1_write_i = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((req_exp.size() + s0_exp.size() + s1_exp.size()) != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("drain_pending_expect", 32'(req_exp.size() + s0_exp.size() + s1_exp.size()), 32'h0);
        check("drain_resp_fifo_left", 32'(resp_fifo.size()), 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        int          n;
        bit          wr;
        bus.s0_address_i    = '0;
        bus.s0_byteenable_i = '0;
        bus.s0_writedata_i  = '0;
        bus.s0_write_i      = 1'b0;
        bus.s0_read_i       = 1'b0;
        bus.s1_address_i    = '0;
        bus.s1_burstcount_i = '0;
        bus.s1_writedata_i  = '0;
        bus.s1_write_i      = 1'b0;
        bus.s1_read_i       = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s0_waitrequest", {31'b0, bus.s0_waitrequest_o}, 32'h1);
        check("rst_s1_waitrequest", {31'b0, bus.s1_waitrequest_o}, 32'h1);
        check("rst_s0_readdata", bus.s0_readdata_o, 32'h0);
        check("rst_s1_readdata", bus.s1_readdata_o, 32'h0);
        check("rst_s1_readdatavalid", {31'b0, bus.s1_readdatavalid_o}, 32'h0);
        check("rst_req_valid", {31'b0, bus.req_valid_o}, 32'h0);
        check("rst_req_data", bus.req_data_o, 32'h0);
        check("rst_rdreq", {31'b0, bus.resp_rdreq_o}, 32'h0);
        check("rst_err", {31'b0, bus.err_o}, 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        plan(1'b0, 1'b1, 32'h10, 4'h3, 1, 32'hA5A5_0001);
        s0_xfer(1'b1, 32'h10, 4'h3);
        drain();
        plan(1'b0, 1'b0, 32'h20, 4'hF, 1, 32'h1234_5678);
        s0_xfer(1'b0, 32'h20, 4'hF);
        drain();
        plan(1'b1, 1'b0, 32'h100, 4'hF, 1, $urandom);
        s1_read(32'h100, 1, 1'b1);
        drain();
        plan(1'b1, 1'b0, 32'h200, 4'hF, MAX_BURST, $urandom);
        s1_read(32'h200, MAX_BURST, 1'b1);
        drain();
        plan(1'b1, 1'b1, 32'h300, 4'hF, MAX_BURST, $urandom);
        s1_write(32'h300, MAX_BURST);
        drain();
        plan(1'b1, 1'b0, 32'h400, 4'hF, 0, $urandom);
        s1_read(32'h400, 0, 1'b0);
        drain();

        plan(1'b0, 1'b1, 32'h500, 4'hC, 1, $urandom);
        plan(1'b1, 1'b0, 32'h600, 4'hF, 5, $urandom);
        fork
            s0_xfer(1'b1, 32'h500, 4'hC);
            s1_read(32'h600, 5, 1'b0);
        join
        drain();
        plan(1'b0, 1'b0, 32'h700, 4'hF, 1, $urandom);
        plan(1'b1, 1'b1, 32'h800, 4'hF, 3, $urandom);
        fork
            s0_xfer(1'b0, 32'h700, 4'hF);
            s1_write(32'h800, 3);
        join
        drain();

        for (int t = 0; t < 30; t++) begin
            a  = $urandom;
            wr = 1'($urandom_range(0, 1));
            n  = $urandom_range(0, MAX_BURST);
            if ($urandom_range(0, 1) == 0) begin
                plan(1'b0, wr, a, 4'($urandom_range(0, 15)), 1, $urandom);
                s0_xfer(wr, a, req_exp[req_exp.size() - (wr ? 3 : 2)][HDR_BE_LSB +: 4]);
            end else begin
                plan(1'b1, wr, a, 4'hF, n, $urandom);
                if (wr) s1_write(a, n);
                else    s1_read(a, n, 1'b0);
            end
        end
        drain();

        check("err_before_timeout", {31'b0, bus.err_o}, 32'h0);
        req_exp.push_back(32'h4F00_0004);
        req_exp.push_back(32'h900);
        repeat (4) s1_exp.push_back(32'hDEAD_BEEF);
        s1_read(32'h900, 4, 1'b0);
        drain();
        check("err_after_timeout", {31'b0, bus.err_o}, 32'h1);
        repeat (20) @(negedge clk);
        check("err_sticky", {31'b0, bus.err_o}, 32'h1);

        rst = 1'b1;
        @(negedge clk);
        check("reset_clears_err", {31'b0, bus.err_o}, 32'h0);
        check("reset_s1_waitrequest", {31'b0, bus.s1_waitrequest_o}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
